// File: rtl/grid_render_pkg.sv
// Shared colours and animation state encoding for the 2048 board renderer.
package grid_render_pkg;

    localparam logic [11:0] RGB_BG   = 12'hEED;
    localparam logic [11:0] RGB_SLOT = 12'hCBA;
    localparam logic [11:0] RGB_B0   = 12'hDCB;
    localparam logic [11:0] RGB_ERR  = 12'hF0F;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_POP  = 1'b1
    } anim_state_e;

endpackage

// File: rtl/grid_renderer_if.sv
// Pixel, board-RAM, sprite-ROM and spawn signals between the renderer and its surroundings.
interface grid_renderer_if;
    logic [9:0]  X_Addr;
    logic [8:0]  Y_Addr;
    logic        frame_start;
    logic [5:0]  BlockID;
    logic [3:0]  BlockType;
    logic [11:0] sprite_addr;
    logic [3:0]  sprite_type;
    logic [11:0] sprite_rgb;
    logic        spawn_valid;
    logic [5:0]  spawn_id;
    logic        spawn_ready;
    logic [11:0] RGB;

    modport master (
        output X_Addr, Y_Addr, frame_start, BlockType, sprite_rgb, spawn_valid, spawn_id,
        input  BlockID, sprite_addr, sprite_type, spawn_ready, RGB
    );

    modport slave (
        input  X_Addr, Y_Addr, frame_start, BlockType, sprite_rgb, spawn_valid, spawn_id,
        output BlockID, sprite_addr, sprite_type, spawn_ready, RGB
    );
endinterface

// File: rtl/tile_locator.sv
// One board axis: pixel coordinate -> tile index, offset inside the tile, tile/board hit flags.
module tile_locator #(
    parameter int unsigned AW     = 10,
    parameter int unsigned GRID_N = 4,
    parameter int unsigned TILE_W = 100,
    parameter int unsigned GAP_W  = 16,
    parameter int unsigned IW     = 2,
    parameter int unsigned LW     = 7
) (
    input  logic [AW-1:0] addr,
    output logic [IW-1:0] idx,
    output logic [LW-1:0] off,
    output logic          in_tile,
    output logic          in_range
);
    localparam int unsigned PITCH = TILE_W + GAP_W;
    localparam int unsigned EDGE  = GRID_N * PITCH + GAP_W;

    // Last tile whose origin is at or before addr wins, so gap pixels keep the preceding cell.
    always_comb begin
        idx      = '0;
        off      = '0;
        in_tile  = 1'b0;
        in_range = 32'(addr) < EDGE;
        for (int unsigned i = 0; i < GRID_N; i++) begin
            if (32'(addr) >= GAP_W * (i + 1) + TILE_W * i) begin
                idx     = IW'(i);
                off     = LW'(32'(addr) - (GAP_W * (i + 1) + TILE_W * i));
                in_tile = 32'(addr) < PITCH * (i + 1);
            end
        end
    end
endmodule

// File: rtl/grid_renderer.sv
// Parametrised 2048 board renderer: 3-stage pixel pipeline plus spawn pop-in animation.
module grid_renderer
    import grid_render_pkg::*;
#(
    parameter int unsigned GRID_N      = 4,
    parameter int unsigned TILE_W      = 100,
    parameter int unsigned GAP_W       = 16,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned MAX_TYPE    = 10,
    parameter int unsigned ANIM_FRAMES = 4,
    parameter int unsigned INSET_STEP  = 12
) (
    input  logic     clk_VGA,
    input  logic     rst,
    grid_renderer_if.slave bus
);
    localparam int unsigned NCELL = GRID_N * GRID_N;
    localparam int unsigned SPR_W = TILE_W >> SCALE_SHIFT;
    localparam int unsigned IW    = $clog2(GRID_N);
    localparam int unsigned LW    = $clog2(TILE_W);
    localparam int unsigned FW    = $clog2(ANIM_FRAMES + 1);

    if (GRID_N < 2 || GRID_N > 8) begin : g_bad_grid
        $error("GRID_N must be in 2..8");
    end
    if (SPR_W * SPR_W > 4096) begin : g_bad_sprite
        $error("sprite does not fit a 12-bit ROM address");
    end
    if (ANIM_FRAMES == 0 || (ANIM_FRAMES - 1) * INSET_STEP >= TILE_W / 2) begin : g_bad_anim
        $error("animation inset exceeds half a tile");
    end

    logic [IW-1:0] col_c, row_c;
    logic [LW-1:0] lx_c, ly_c;
    logic          x_tile_c, y_tile_c, x_range_c, y_range_c;

    tile_locator #(.AW(10), .GRID_N(GRID_N), .TILE_W(TILE_W), .GAP_W(GAP_W), .IW(IW), .LW(LW))
        u_loc_x (.addr(bus.X_Addr), .idx(col_c), .off(lx_c), .in_tile(x_tile_c), .in_range(x_range_c));
    tile_locator #(.AW(9), .GRID_N(GRID_N), .TILE_W(TILE_W), .GAP_W(GAP_W), .IW(IW), .LW(LW))
        u_loc_y (.addr(bus.Y_Addr), .idx(row_c), .off(ly_c), .in_tile(y_tile_c), .in_range(y_range_c));

    anim_state_e   state_q;
    logic [5:0]    anim_id_q;
    logic [FW-1:0] frame_cnt_q;
    logic          spawn_ready_q;

    logic [5:0]    block_id_q;
    logic [LW-1:0] s1_lx, s1_ly;
    logic          s1_in_tile, s1_in_board;
    logic          s2_in_tile, s2_in_board, s2_pop;
    logic [3:0]    s2_type;
    logic [11:0]   sprite_addr_q;
    logic [11:0]   rgb_q;

    logic [31:0]   inset_c;
    logic          pop_c;
    logic [11:0]   sprite_addr_c;
    logic [11:0]   rgb_c;

    assign bus.BlockID     = block_id_q;
    assign bus.sprite_addr = sprite_addr_q;
    assign bus.sprite_type = s2_type;
    assign bus.spawn_ready = spawn_ready_q;
    assign bus.RGB         = rgb_q;

    // Pop-in FSM: one animation at a time, counted in whole frames.
    always_ff @(posedge clk_VGA or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            anim_id_q     <= '0;
            frame_cnt_q   <= '0;
            spawn_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.spawn_valid && spawn_ready_q && 32'(bus.spawn_id) < NCELL) begin
                        state_q       <= ST_POP;
                        anim_id_q     <= bus.spawn_id;
                        frame_cnt_q   <= '0;
                        spawn_ready_q <= 1'b0;
                    end
                end
                ST_POP: begin
                    if (bus.frame_start) begin
                        if (32'(frame_cnt_q) == ANIM_FRAMES - 1) begin
                            state_q       <= ST_IDLE;
                            frame_cnt_q   <= '0;
                            spawn_ready_q <= 1'b1;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        inset_c = (ANIM_FRAMES - 1 - 32'(frame_cnt_q)) * INSET_STEP;
        pop_c   = (state_q == ST_POP) && (block_id_q == anim_id_q) &&
                  (32'(s1_lx) < inset_c || 32'(s1_lx) >= TILE_W - inset_c ||
                   32'(s1_ly) < inset_c || 32'(s1_ly) >= TILE_W - inset_c);
        // ROM rows are stored bottom-up, hence the flipped row index.
        sprite_addr_c = 12'((SPR_W - 1 - (32'(s1_ly) >> SCALE_SHIFT)) * SPR_W +
                            (32'(s1_lx) >> SCALE_SHIFT));
    end

    always_comb begin
        rgb_c = bus.sprite_rgb;
        if (!s2_in_board)                    rgb_c = RGB_BG;
        else if (!s2_in_tile)                rgb_c = RGB_SLOT;
        else if (s2_type == 4'd0 || s2_pop)  rgb_c = RGB_B0;
        else if (32'(s2_type) > MAX_TYPE)    rgb_c = RGB_ERR;
    end

    // S1 locate, S2 fetch type / sprite address, S3 colour select.
    always_ff @(posedge clk_VGA or negedge rst) begin
        if (!rst) begin
            block_id_q    <= '0;
            s1_lx         <= '0;
            s1_ly         <= '0;
            s1_in_tile    <= 1'b0;
            s1_in_board   <= 1'b0;
            s2_in_tile    <= 1'b0;
            s2_in_board   <= 1'b0;
            s2_pop        <= 1'b0;
            s2_type       <= '0;
            sprite_addr_q <= '0;
            rgb_q         <= RGB_BG;
        end else begin
            block_id_q    <= 6'(32'(row_c) * GRID_N + 32'(col_c));
            s1_lx         <= lx_c;
            s1_ly         <= ly_c;
            s1_in_tile    <= x_tile_c & y_tile_c;
            s1_in_board   <= x_range_c & y_range_c;
            s2_in_tile    <= s1_in_tile;
            s2_in_board   <= s1_in_board;
            s2_pop        <= pop_c;
            s2_type       <= bus.BlockType;
            sprite_addr_q <= sprite_addr_c;
            rgb_q         <= rgb_c;
        end
    end
endmodule

// File: tb/tb_grid_renderer.sv
// Self-checking bench for grid_renderer: vector table, random pixel stream, pop-in sequences.
module tb_grid_renderer;
    import grid_render_pkg::*;

    logic clk_VGA = 1'b0;
    logic rst     = 1'b0;
    always #5 clk_VGA = ~clk_VGA;

    grid_renderer_if bus ();
    grid_renderer_if bus8 ();

    grid_renderer u_dut (.clk_VGA(clk_VGA), .rst(rst), .bus(bus));
    grid_renderer #(.GRID_N(8), .TILE_W(48), .GAP_W(8), .INSET_STEP(6))
        u_dut8 (.clk_VGA(clk_VGA), .rst(rst), .bus(bus8));

    logic [3:0] board  [64];
    logic [3:0] board8 [64];

    function automatic logic [11:0] rom(input logic [3:0] t, input logic [11:0] a);
        return (a * 12'd7 + {t, 8'h00} + 12'(t)) ^ 12'h3C5;
    endfunction

    assign bus.BlockType   = board[bus.BlockID];
    assign bus.sprite_rgb  = rom(bus.sprite_type, bus.sprite_addr);
    assign bus8.BlockType  = board8[bus8.BlockID];
    assign bus8.sprite_rgb = rom(bus8.sprite_type, bus8.sprite_addr);

    int n_assert = 0;
    int n_fail   = 0;

    bit m_pop   = 1'b0;
    int m_id    = 0;
    int m_frame = 0;

    typedef struct {
        logic [11:0] rgb;
        logic [5:0]  id;
        logic [11:0] addr;
        logic [3:0]  typ;
        bit          full;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          x;
        int          y;
        logic [3:0]  bt;
        logic [5:0]  id;
        logic [11:0] addr;
        logic [11:0] rgb;
        bit          use_rom;
        bit          chk_ia;
    } vec_t;
    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent reference: geometry by division rather than range compare.
    function automatic logic [11:0] exp_rgb(input int x, input int y);
        int cx, cy, ox, oy, lx, ly, id, inset;
        logic [3:0] t;
        bit pop;
        if (x >= 480 || y >= 480) return RGB_BG;
        cx = x / 116; ox = x % 116;
        cy = y / 116; oy = y % 116;
        if (ox < 16 || oy < 16) return RGB_SLOT;
        lx = ox - 16; ly = oy - 16;
        id = cy * 4 + cx;
        t = board[id];
        inset = (3 - m_frame) * 12;
        pop = m_pop && id == m_id &&
              (lx < inset || lx >= 100 - inset || ly < inset || ly >= 100 - inset);
        if (t == 4'd0 || pop) return RGB_B0;
        if (t > 4'd10) return RGB_ERR;
        return rom(t, 12'((49 - ly / 2) * 50 + lx / 2));
    endfunction

    // Hold one pixel through the pipe, then compare against the queued expectation.
    task automatic check_held(input int x, input int y, input exp_t e, input string nm);
        exp_t g;
        @(posedge clk_VGA); #1;
        bus.X_Addr = 10'(x);
        bus.Y_Addr = 9'(y);
        sb.push_back(e);
        repeat (3) @(posedge clk_VGA);
        @(negedge clk_VGA);
        g = sb.pop_front();
        chk({nm, "_rgb"}, 32'(bus.RGB), 32'(g.rgb));
        if (g.full) begin
            chk({nm, "_id"},   32'(bus.BlockID),     32'(g.id));
            chk({nm, "_addr"}, 32'(bus.sprite_addr), 32'(g.addr));
            chk({nm, "_type"}, 32'(bus.sprite_type), 32'(g.typ));
        end
    endtask

    task automatic check_pix(input int x, input int y, input logic [11:0] rgb, input string nm);
        exp_t e;
        e.rgb = rgb; e.id = '0; e.addr = '0; e.typ = '0; e.full = 1'b0;
        check_held(x, y, e, nm);
    endtask

    task automatic spawn(input int id, input bit fs);
        @(posedge clk_VGA); #1;
        bus.spawn_valid = 1'b1;
        bus.spawn_id    = 6'(id);
        bus.frame_start = fs;
        @(posedge clk_VGA); #1;
        bus.spawn_valid = 1'b0;
        bus.frame_start = 1'b0;
        @(negedge clk_VGA);
    endtask

    task automatic pulse_frame();
        @(posedge clk_VGA); #1;
        bus.frame_start = 1'b1;
        @(posedge clk_VGA); #1;
        bus.frame_start = 1'b0;
        @(negedge clk_VGA);
    endtask

    task automatic check8(input int x, input int y, input bit cid, input logic [5:0] id,
                          input logic [11:0] rgb, input string nm);
        @(posedge clk_VGA); #1;
        bus8.X_Addr = 10'(x);
        bus8.Y_Addr = 9'(y);
        repeat (3) @(posedge clk_VGA);
        @(negedge clk_VGA);
        if (cid) chk({nm, "_id"}, 32'(bus8.BlockID), 32'(id));
        chk({nm, "_rgb"}, 32'(bus8.RGB), 32'(rgb));
    endtask

    initial begin
        exp_t e, g;
        int x, y;

        bus.X_Addr = '0; bus.Y_Addr = '0; bus.frame_start = 1'b0;
        bus.spawn_valid = 1'b0; bus.spawn_id = '0;
        bus8.X_Addr = '0; bus8.Y_Addr = '0; bus8.frame_start = 1'b0;
        bus8.spawn_valid = 1'b0; bus8.spawn_id = '0;
        for (int i = 0; i < 64; i++) begin
            board[i]  = 4'd1;
            board8[i] = 4'd2;
        end

        vt[0]  = '{16,  16,  4'd1,  6'd0,  12'd2450, 12'h000, 1'b1, 1'b1};
        vt[1]  = '{15,  16,  4'd1,  6'd0,  12'd0,    RGB_SLOT, 1'b0, 1'b0};
        vt[2]  = '{479, 16,  4'd1,  6'd0,  12'd0,    RGB_SLOT, 1'b0, 1'b0};
        vt[3]  = '{480, 16,  4'd1,  6'd0,  12'd0,    RGB_BG,   1'b0, 1'b0};
        vt[4]  = '{132, 248, 4'd0,  6'd9,  12'd2450, RGB_B0,   1'b0, 1'b1};
        vt[5]  = '{132, 248, 4'd12, 6'd9,  12'd2450, RGB_ERR,  1'b0, 1'b1};
        vt[6]  = '{16,  16,  4'd10, 6'd0,  12'd2450, 12'h000,  1'b1, 1'b1};
        vt[7]  = '{16,  16,  4'd11, 6'd0,  12'd2450, RGB_ERR,  1'b0, 1'b1};
        vt[8]  = '{115, 115, 4'd1,  6'd0,  12'd49,   12'h000,  1'b1, 1'b1};
        vt[9]  = '{116, 116, 4'd1,  6'd0,  12'd0,    RGB_SLOT, 1'b0, 1'b0};
        vt[10] = '{463, 463, 4'd1,  6'd15, 12'd49,   12'h000,  1'b1, 1'b1};
        vt[11] = '{16,  479, 4'd1,  6'd0,  12'd0,    RGB_SLOT, 1'b0, 1'b0};
        vt[12] = '{16,  480, 4'd1,  6'd0,  12'd0,    RGB_BG,   1'b0, 1'b0};

        #12;
        chk("rst_rgb",   32'(bus.RGB),         32'(RGB_BG));
        chk("rst_id",    32'(bus.BlockID),     32'd0);
        chk("rst_addr",  32'(bus.sprite_addr), 32'd0);
        chk("rst_type",  32'(bus.sprite_type), 32'd0);
        chk("rst_ready", 32'(bus.spawn_ready), 32'd1);
        @(negedge clk_VGA);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            for (int c = 0; c < 64; c++) board[c] = vt[i].bt;
            e.rgb  = vt[i].use_rom ? rom(vt[i].bt, vt[i].addr) : vt[i].rgb;
            e.id   = vt[i].id;
            e.addr = vt[i].addr;
            e.typ  = vt[i].bt;
            e.full = vt[i].chk_ia;
            check_held(vt[i].x, vt[i].y, e, $sformatf("vec%0d", i));
        end

        // Back-to-back random pixels over a random board; RGB trails input by 3 cycles.
        for (int c = 0; c < 64; c++) board[c] = 4'($urandom_range(12));
        sb.delete();
        for (int k = 0; k < 300; k++) begin
            @(posedge clk_VGA); #1;
            x = (k < 297) ? int'($urandom_range(511)) : 1000;
            y = (k < 297) ? int'($urandom_range(511)) : 500;
            bus.X_Addr = 10'(x);
            bus.Y_Addr = 9'(y);
            e.rgb = exp_rgb(x, y); e.id = '0; e.addr = '0; e.typ = '0; e.full = 1'b0;
            sb.push_back(e);
            @(negedge clk_VGA);
            if (sb.size() == 4) begin
                g = sb.pop_front();
                chk($sformatf("stream%0d", k), 32'(bus.RGB), 32'(g.rgb));
            end
        end
        sb.delete();

        for (int c = 0; c < 64; c++) board[c] = 4'd3;
        spawn(16, 1'b0);
        chk("bad_id_ready", 32'(bus.spawn_ready), 32'd1);
        spawn(5, 1'b0);
        chk("accept_ready", 32'(bus.spawn_ready), 32'd0);
        m_pop = 1'b1; m_id = 5; m_frame = 0;
        check_pix(167, 182, RGB_B0, "pop_f0_ring");
        check_pix(168, 182, exp_rgb(168, 182), "pop_f0_inner");
        spawn(6, 1'b0);
        chk("busy_ready", 32'(bus.spawn_ready), 32'd0);
        check_pix(248, 182, exp_rgb(248, 182), "busy_no_retarget");
        for (int f = 1; f <= 4; f++) begin
            pulse_frame();
            chk($sformatf("frame%0d_ready", f), 32'(bus.spawn_ready), (f == 4) ? 32'd1 : 32'd0);
            if (f == 4) m_pop = 1'b0;
            m_frame = f % 4;
            if (f == 1) begin
                check_pix(155, 182, RGB_B0, "pop_f1_ring");
                check_pix(156, 182, exp_rgb(156, 182), "pop_f1_inner");
            end
        end
        check_pix(132, 182, exp_rgb(132, 182), "pop_done_edge");

        spawn(5, 1'b1);
        chk("coinc_ready", 32'(bus.spawn_ready), 32'd0);
        m_pop = 1'b1; m_id = 5; m_frame = 0;
        check_pix(167, 182, RGB_B0, "coinc_f0_ring");

        @(negedge clk_VGA);
        rst = 1'b0;
        #1;
        chk("midpop_rst_ready", 32'(bus.spawn_ready), 32'd1);
        chk("midpop_rst_rgb",   32'(bus.RGB),         32'(RGB_BG));
        @(negedge clk_VGA);
        rst = 1'b1;
        m_pop = 1'b0; m_frame = 0;
        check_pix(167, 182, exp_rgb(167, 182), "after_rst_no_inset");

        check8(456, 456, 1'b1, 6'd63, RGB_BG, "g8_edge");
        check8(464, 100, 1'b0, 6'd0,  RGB_BG, "g8_out");
        check8(400, 400, 1'b1, 6'd63, rom(4'd2, 12'd552), "g8_last");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
